// File: rtl/display_scan_if.sv
// Host-side write/commit/control bundle for the 7-segment scan controller.
interface display_scan_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_digit;
  logic [6:0] wr_seg;
  logic       commit;
  logic       pending;
  logic [3:0] bright;
  logic [3:0] blink_mask;

  modport master (
    output wr_valid, wr_digit, wr_seg, commit, bright, blink_mask,
    input  wr_ready, pending
  );

  modport slave (
    input  wr_valid, wr_digit, wr_seg, commit, bright, blink_mask,
    output wr_ready, pending
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with shadow/active frame buffers,
// slot blanking, PWM brightness and per-digit blink.
module display_scan_ctrl #(
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK        = 50,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  display_scan_if.slave       host,
  output logic [3:0]          ED_out,
  output logic [6:0]          D_out
);

  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK);
  localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [6:0]       SEG_OFF    = 7'h7F;

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [3:0]       pwm_cnt_q, pwm_cnt_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             pending_q, pending_d;
  logic [3:0][6:0]  shadow_q, shadow_d;
  logic [3:0][6:0]  active_q, active_d;
  logic [3:0]       ed_q, ed_d;
  logic [6:0]       d_q, d_d;

  logic slot_wrap, frame_end, lit;

  // Timing chain, buffer management and next display outputs.
  always_comb begin
    slot_cnt_d    = slot_cnt_q;
    digit_d       = digit_q;
    pwm_cnt_d     = pwm_cnt_q + 4'd1;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    pending_d     = pending_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    ed_d          = 4'hF;
    d_d           = SEG_OFF;

    slot_wrap = (slot_cnt_q == SLOT_LAST);
    frame_end = slot_wrap && (digit_q == 2'd3);

    if (slot_wrap) begin
      slot_cnt_d = '0;
      digit_d    = digit_q + 2'd1;
    end else begin
      slot_cnt_d = slot_cnt_q + CNT_W'(1);
    end

    if (frame_end) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FRM_W'(1);
      end
    end

    // Copy and write are exclusive: writes are only accepted while nothing is pending.
    if (pending_q) begin
      if (frame_end) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else begin
      if (host.wr_valid) shadow_d[host.wr_digit] = host.wr_seg;
      if (host.commit)   pending_d = 1'b1;
    end

    lit = (slot_cnt_q >= BLANK_END)
        && ((host.bright == 4'd15) || (pwm_cnt_q < host.bright))
        && !(blink_phase_q && host.blink_mask[digit_q]);

    if (lit) begin
      ed_d = ~(4'b0001 << digit_q);
      d_d  = active_q[digit_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q    <= '0;
      digit_q       <= 2'd0;
      pwm_cnt_q     <= 4'd0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pending_q     <= 1'b0;
      shadow_q      <= {4{SEG_OFF}};
      active_q      <= {4{SEG_OFF}};
      ed_q          <= 4'hF;
      d_q           <= SEG_OFF;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      digit_q       <= digit_d;
      pwm_cnt_q     <= pwm_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      pending_q     <= pending_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      ed_q          <= ed_d;
      d_q           <= d_d;
    end
  end

  assign host.wr_ready = ~pending_q;
  assign host.pending  = pending_q;
  assign ED_out        = ed_q;
  assign D_out         = d_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a cycle-index arithmetic reference model.
module tb_display_scan_ctrl;
  localparam int unsigned P     = 40;
  localparam int unsigned BL    = 4;
  localparam int unsigned BF    = 2;
  localparam int unsigned FRAME = 4 * P;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ED_out;
  logic [6:0] D_out;

  display_scan_if host_if ();

  display_scan_ctrl #(
    .PRESCALE(P), .BLANK(BL), .BLINK_FRAMES(BF), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (host_if),
    .ED_out(ED_out),
    .D_out (D_out)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int unsigned n_cyc = 0;
  logic [6:0]  m_shadow [4];
  logic [6:0]  m_active [4];
  bit          m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, obs, exp, n_cyc, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 7'h7F;
      m_active[i] = 7'h7F;
    end
    m_pend = 1'b0;
  endfunction

  // Display output after clock edge e, from the cycle index alone.
  function automatic void model_out(input int unsigned e, input logic [3:0] br,
                                    input logic [3:0] mask,
                                    output logic [3:0] ed, output logic [6:0] d);
    int unsigned slot  = e % P;
    int unsigned dig   = (e / P) % 4;
    int unsigned frame = e / FRAME;
    int unsigned phase = (frame / BF) % 2;
    int unsigned pwm   = e % 16;
    bit lit;
    lit = (slot >= BL) && ((br == 4'd15) || (pwm < 32'(br))) && !(phase == 1 && mask[dig] == 1'b1);
    ed = 4'hF;
    d  = 7'h7F;
    if (lit) begin
      ed[dig] = 1'b0;
      d       = m_active[dig];
    end
  endfunction

  task automatic step(input bit v, input logic [1:0] dg, input logic [6:0] sg, input bit cm);
    logic [3:0] e_ed;
    logic [6:0] e_d;
    bit         fe;
    host_if.wr_valid = v;
    host_if.wr_digit = dg;
    host_if.wr_seg   = sg;
    host_if.commit   = cm;
    model_out(n_cyc, host_if.bright, host_if.blink_mask, e_ed, e_d);
    fe = ((n_cyc % FRAME) == FRAME - 1);
    chk("wr_ready", 32'(host_if.wr_ready), 32'(!m_pend));
    @(posedge clk);
    #1;
    chk("ED_out", 32'(ED_out), 32'(e_ed));
    chk("D_out", 32'(D_out), 32'(e_d));
    if (m_pend) begin
      if (fe) begin
        for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
        m_pend = 1'b0;
      end
    end else begin
      if (v)  m_shadow[dg] = sg;
      if (cm) m_pend = 1'b1;
    end
    chk("pending", 32'(host_if.pending), 32'(m_pend));
    n_cyc++;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 7'h00, 1'b0);
  endtask

  // Advance so the last checked edge sits at offset ph within a frame.
  task automatic run_to_phase(input int unsigned ph);
    while ((n_cyc % FRAME) != ph) idle();
    idle();
  endtask

  task automatic wait_copy();
    int guard = 0;
    while (m_pend && guard < 2 * FRAME) begin
      idle();
      guard++;
    end
    chk("copy_timeout", 32'(m_pend), 32'd0);
  endtask

  initial begin
    rst_n               = 1'b0;
    host_if.wr_valid    = 1'b0;
    host_if.wr_digit    = 2'd0;
    host_if.wr_seg      = 7'h00;
    host_if.commit      = 1'b0;
    host_if.bright      = 4'd15;
    host_if.blink_mask  = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ED", 32'(ED_out), 32'h0F);
    chk("rst_D", 32'(D_out), 32'h7F);
    chk("rst_pending", 32'(host_if.pending), 32'd0);
    chk("rst_ready", 32'(host_if.wr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    n_cyc = 0;

    // Load four digits and commit; nothing visible until the first frame end.
    step(1'b1, 2'd0, 7'h78, 1'b0);
    step(1'b1, 2'd1, 7'h0F, 1'b0);
    step(1'b1, 2'd2, 7'h1C, 1'b0);
    step(1'b1, 2'd3, 7'h63, 1'b0);
    step(1'b0, 2'd0, 7'h00, 1'b1);
    while (n_cyc <= 50) idle();
    chk("t1_pre_D", 32'(D_out), 32'h7F);
    chk("t1_pre_pend", 32'(host_if.pending), 32'd1);
    run_to_phase(10);
    chk("t1_d0_ED", 32'(ED_out), 32'hE);
    chk("t1_d0_D", 32'(D_out), 32'h78);
    run_to_phase(90);
    chk("t1_d2_ED", 32'(ED_out), 32'hB);
    chk("t1_d2_D", 32'(D_out), 32'h1C);
    run_to_phase(2);
    chk("t1_blank_ED", 32'(ED_out), 32'hF);

    // Held write stalls across a commit; the new value waits for a second commit.
    step(1'b0, 2'd0, 7'h00, 1'b1);
    for (int g = 0; g < 2 * FRAME && m_pend; g++) step(1'b1, 2'd0, 7'h00, 1'b0);
    step(1'b1, 2'd0, 7'h00, 1'b0);
    run_to_phase(10);
    chk("t2_old_D", 32'(D_out), 32'h78);
    step(1'b0, 2'd0, 7'h00, 1'b1);
    wait_copy();
    run_to_phase(10);
    chk("t2_new_D", 32'(D_out), 32'h00);

    // Write and commit on the same cycle.
    step(1'b1, 2'd1, 7'h00, 1'b1);
    wait_copy();
    run_to_phase(50);
    chk("t5_ED", 32'(ED_out), 32'hD);
    chk("t5_D", 32'(D_out), 32'h00);

    // Brightness off keeps every digit dark.
    host_if.bright = 4'd0;
    for (int i = 0; i < FRAME; i++) begin
      idle();
      chk("t3_dark", 32'(ED_out), 32'hF);
    end
    host_if.bright = 4'd8;
    for (int i = 0; i < FRAME; i++) idle();
    host_if.bright = 4'd15;

    // Blink digit 2 across several half-periods.
    host_if.blink_mask = 4'b0100;
    for (int i = 0; i < 5 * FRAME; i++) idle();
    host_if.blink_mask = 4'b0000;
    for (int i = 0; i < FRAME; i++) idle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0:       host_if.bright = 4'd15;
          1:       host_if.bright = 4'd8;
          2:       host_if.bright = 4'd0;
          default: host_if.bright = 4'($urandom_range(0, 15));
        endcase
        host_if.blink_mask = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      step(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
           7'($urandom_range(0, 127)), ($urandom_range(0, 39) == 0));
    end

    // Reset in the middle of a slot with a commit pending.
    host_if.bright     = 4'd15;
    host_if.blink_mask = 4'd0;
    wait_copy();
    step(1'b1, 2'd2, 7'h12, 1'b1);
    for (int i = 0; i < 7; i++) idle();
    chk("t6_pend_before", 32'(host_if.pending), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ED", 32'(ED_out), 32'hF);
    chk("t6_D", 32'(D_out), 32'h7F);
    chk("t6_pending", 32'(host_if.pending), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_cyc = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      chk("t6_blank_D", 32'(D_out), 32'h7F);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
